pong_match_ctrl: RTL and testbench

//  Next-generation match controller for the pingpong game: owns the registered game state, both scores and the winner.

---
 rtl/pong_pkg.sv | 18 +
 rtl/pong_btn_edge.sv | 27 ++
 rtl/pong_match_ctrl.sv | 158 +++++++++++++++
 tb/tb_pong_match_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the pingpong match controller and the blocks that
// consume its game state and winner outputs.
package pong_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_P1_SERVE = 3'd0;
  localparam logic [STATE_W-1:0] S_P2_SERVE = 3'd1;
  localparam logic [STATE_W-1:0] S_PLAYING  = 3'd2;
  localparam logic [STATE_W-1:0] S_PAUSED   = 3'd3;
  localparam logic [STATE_W-1:0] S_END      = 3'd4;

  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_P1   = 2'd1;
  localparam logic [1:0] W_P2   = 2'd2;
  localparam logic [1:0] W_DRAW = 2'd3;

endpackage

// File: rtl/pong_btn_edge.sv
// Registered rising-edge detector. A level already high when reset releases
// must drop once before it can produce an edge.
module pong_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic rise_o
);

  logic hist_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hist_q <= in_i;
      if (!in_i) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rise_o = in_i & ~hist_q & armed_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match controller: owns game state, both scores and the winner. Scoring,
// win and serve decisions are combinational; all outputs are registered.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W     = 4,
  parameter int GOAL_POINTS = 7,
  parameter int WIN_BY_TWO  = 0,
  parameter int SERVE_MODE  = 0,
  parameter int SERVE_ROT   = 2,
  parameter int X_W         = 10,
  parameter int P1_BOARD_X  = 150,
  parameter int P2_BOARD_X  = 490,
  parameter int TIME_W      = 6,
  parameter int GAME_TIMES  = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p1l,
  input  logic               p1r,
  input  logic               p2l,
  input  logic               p2r,
  input  logic               pause,
  input  logic [X_W-1:0]     ball_x,
  input  logic [TIME_W-1:0]  time_cnt,
  output logic [STATE_W-1:0] game_state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic               point_pulse
);

  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = 1;

  logic serve_p1, serve_p2, pause_e;
  logic goal_p1, goal_p2, timeout;

  logic [STATE_W-1:0] state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [SCORE_W-1:0] n1, n2;
  logic [1:0]         winner_q, winner_d;
  logic               pulse_q, pulse_d;

  pong_btn_edge u_edge_p1 (.clk(clk), .reset(reset), .in_i(p1l | p1r), .rise_o(serve_p1));
  pong_btn_edge u_edge_p2 (.clk(clk), .reset(reset), .in_i(p2l | p2r), .rise_o(serve_p2));
  pong_btn_edge u_edge_pa (.clk(clk), .reset(reset), .in_i(pause),     .rise_o(pause_e));

  assign goal_p1 = int'(ball_x) > P2_BOARD_X;
  assign goal_p2 = int'(ball_x) < P1_BOARD_X;
  assign timeout = int'(time_cnt) >= GAME_TIMES;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (int'(s) == SCORE_MAX) ? s : s + SCORE_ONE;
  endfunction

  // A saturated score can no longer grow, so it wins even without a two-point lead.
  function automatic logic wins(input logic [SCORE_W-1:0] s, input logic [SCORE_W-1:0] o);
    return (int'(s) >= GOAL_POINTS) &&
           ((WIN_BY_TWO == 0) || (int'(s) >= int'(o) + 2) || (int'(s) == SCORE_MAX));
  endfunction

  function automatic logic [1:0] timeout_winner(input logic [SCORE_W-1:0] a,
                                                input logic [SCORE_W-1:0] b);
    if (a > b) return W_P1;
    if (a < b) return W_P2;
    return W_DRAW;
  endfunction

  function automatic logic [STATE_W-1:0] rot_server(input logic [SCORE_W-1:0] a,
                                                    input logic [SCORE_W-1:0] b);
    int turn;
    turn = (int'(a) + int'(b)) / SERVE_ROT;
    return (turn % 2 == 0) ? S_P1_SERVE : S_P2_SERVE;
  endfunction

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    pulse_d  = 1'b0;
    n1       = p1_q;
    n2       = p2_q;
    case (state_q)
      S_P1_SERVE, S_P2_SERVE: begin
        if (timeout) begin
          state_d  = S_END;
          winner_d = timeout_winner(p1_q, p2_q);
        end else if ((state_q == S_P1_SERVE) ? serve_p1 : serve_p2) begin
          state_d = S_PLAYING;
        end
      end
      S_PLAYING: begin
        if (goal_p1 || goal_p2) begin
          if (goal_p1) n1 = sat_inc(p1_q);
          else         n2 = sat_inc(p2_q);
          p1_d    = n1;
          p2_d    = n2;
          pulse_d = 1'b1;
          // Timeout is judged on the scores that include this goal.
          if (goal_p1 && wins(n1, n2)) begin
            state_d  = S_END;
            winner_d = W_P1;
          end else if (goal_p2 && wins(n2, n1)) begin
            state_d  = S_END;
            winner_d = W_P2;
          end else if (timeout) begin
            state_d  = S_END;
            winner_d = timeout_winner(n1, n2);
          end else if (SERVE_MODE == 0) begin
            state_d = goal_p1 ? S_P2_SERVE : S_P1_SERVE;
          end else begin
            state_d = rot_server(n1, n2);
          end
        end else if (timeout) begin
          state_d  = S_END;
          winner_d = timeout_winner(p1_q, p2_q);
        end else if (pause_e) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (timeout) begin
          state_d  = S_END;
          winner_d = timeout_winner(p1_q, p2_q);
        end else if (pause_e) begin
          state_d = S_PLAYING;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_P1_SERVE;
      p1_q     <= '0;
      p2_q     <= '0;
      winner_q <= W_NONE;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
      pulse_q  <= pulse_d;
    end
  end

  assign game_state  = state_q;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign winner      = winner_q;
  assign point_pulse = pulse_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: three instances (defaults, win-by-two,
// rotating serve) share one stimulus stream; each test checks the relevant one.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p1l = 0, p1r = 0, p2l = 0, p2r = 0, pause = 0;
  logic [9:0] ball_x = 10'd300;
  logic [5:0] time_cnt = 6'd0;

  logic [2:0] d_state, w_state, s_state;
  logic [3:0] d_p1, d_p2, w_p1, w_p2, s_p1, s_p2;
  logic [1:0] d_win, w_win, s_win;
  logic       d_pulse, w_pulse, s_pulse;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pong_match_ctrl u_def (
    .clk(clk), .reset(reset), .p1l(p1l), .p1r(p1r), .p2l(p2l), .p2r(p2r),
    .pause(pause), .ball_x(ball_x), .time_cnt(time_cnt),
    .game_state(d_state), .p1_score(d_p1), .p2_score(d_p2),
    .winner(d_win), .point_pulse(d_pulse)
  );

  pong_match_ctrl #(.WIN_BY_TWO(1)) u_w2 (
    .clk(clk), .reset(reset), .p1l(p1l), .p1r(p1r), .p2l(p2l), .p2r(p2r),
    .pause(pause), .ball_x(ball_x), .time_cnt(time_cnt),
    .game_state(w_state), .p1_score(w_p1), .p2_score(w_p2),
    .winner(w_win), .point_pulse(w_pulse)
  );

  pong_match_ctrl #(.SERVE_MODE(1), .SERVE_ROT(2)) u_rot (
    .clk(clk), .reset(reset), .p1l(p1l), .p1r(p1r), .p2l(p2l), .p2r(p2r),
    .pause(pause), .ball_x(ball_x), .time_cnt(time_cnt),
    .game_state(s_state), .p1_score(s_p1), .p2_score(s_p2),
    .winner(s_win), .point_pulse(s_pulse)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic hold_p1l);
    reset = 1'b1;
    p1l = hold_p1l; p1r = 0; p2l = 0; p2r = 0; pause = 0;
    ball_x = 10'd300; time_cnt = 6'd0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  // Both players press together; only the serving player's edge matters.
  task automatic serve();
    p1r = 1; p2r = 1;
    step();
    p1r = 0; p2r = 0;
    step();
  endtask

  task automatic point(input bit to_p1);
    serve();
    ball_x = to_p1 ? 10'd495 : 10'd100;
    step();
    ball_x = 10'd300;
    step();
  endtask

  initial begin
    // Test 1: reset state and a first point
    do_reset(1'b0);
    check("t1 reset state", d_state, 0);
    check("t1 reset p1", d_p1, 0);
    check("t1 reset p2", d_p2, 0);
    check("t1 reset winner", d_win, 0);
    check("t1 reset pulse", d_pulse, 0);
    p1r = 1; step(); p1r = 0;
    check("t1 serve->playing", d_state, 2);
    step();
    ball_x = 10'd495; step(); ball_x = 10'd300;
    check("t1 p1 score", d_p1, 1);
    check("t1 pulse high", d_pulse, 1);
    check("t1 p2 serves", d_state, 1);
    step();
    check("t1 pulse drop", d_pulse, 0);

    // Test 2: p1 wins 7-3 and S_END freezes
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) point(1'b0);
    for (int i = 0; i < 7; i++) point(1'b1);
    check("t2 winner", d_win, 1);
    check("t2 end state", d_state, 4);
    ball_x = 10'd495; step(); ball_x = 10'd300;
    check("t2 end no pulse", d_pulse, 0);
    serve(); step();
    check("t2 frozen p1", d_p1, 7);
    check("t2 frozen p2", d_p2, 3);
    check("t2 still end", d_state, 4);

    // Test 3a: win-by-two from 6-6
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin point(1'b1); point(1'b0); end
    point(1'b1);
    check("t3 7-6 p1", w_p1, 7);
    check("t3 7-6 no win", w_win, 0);
    check("t3 7-6 p2 serves", w_state, 1);
    point(1'b1);
    check("t3 8-6 winner", w_win, 1);
    check("t3 8-6 end", w_state, 4);

    // Test 3b: saturation at 15 wins with a one-point lead
    do_reset(1'b0);
    for (int i = 0; i < 14; i++) begin point(1'b1); point(1'b0); end
    check("t3 14-14 no win", w_win, 0);
    check("t3 14-14 p2", w_p2, 14);
    point(1'b1);
    check("t3 15-14 p1", w_p1, 15);
    check("t3 15-14 winner", w_win, 1);
    check("t3 15-14 end", w_state, 4);

    // Test 4a: timeout while paused at 3-3 is a draw
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin point(1'b1); point(1'b0); end
    serve();
    pause = 1; step(); pause = 0;
    check("t4 paused", d_state, 3);
    step();
    ball_x = 10'd495; step(); ball_x = 10'd300;
    check("t4 paused ignores ball", d_p1, 3);
    check("t4 still paused", d_state, 3);
    time_cnt = 6'd60; step();
    check("t4 draw winner", d_win, 3);
    check("t4 draw end", d_state, 4);

    // Test 4b: goal and timeout together at 3-3
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin point(1'b1); point(1'b0); end
    serve();
    ball_x = 10'd100; time_cnt = 6'd60; step();
    ball_x = 10'd300;
    check("t4 goal+timeout p2", d_p2, 4);
    check("t4 goal+timeout winner", d_win, 2);
    check("t4 goal+timeout end", d_state, 4);
    check("t4 goal+timeout pulse", d_pulse, 1);

    // Test 5a: button held through reset
    do_reset(1'b1);
    step();
    check("t5 held no serve", d_state, 0);
    p1l = 0; step();
    check("t5 released", d_state, 0);
    p1l = 1; step(); p1l = 0;
    check("t5 re-press serves", d_state, 2);

    // Test 5b: p2 buttons ignored while p1 serves
    do_reset(1'b0);
    p2l = 1; step(); p2l = 0; step();
    p2r = 1; step(); p2r = 0; step();
    check("t5 p2 ignored", d_state, 0);

    // Test 6: rotating serve, independent of the scorer
    do_reset(1'b0);
    check("t6 total0 p1", s_state, 0);
    point(1'b1);
    check("t6 total1 p1", s_state, 0);
    point(1'b0);
    check("t6 total2 p2", s_state, 1);
    point(1'b0);
    check("t6 total3 p2", s_state, 1);
    point(1'b1);
    check("t6 total4 p1", s_state, 0);

    // Test 6b: reset beats a goal mid-rally
    serve();
    check("t6 rally", s_state, 2);
    ball_x = 10'd495; reset = 1'b1; step();
    ball_x = 10'd300;
    check("t6 reset state", s_state, 0);
    check("t6 reset p1", s_p1, 0);
    check("t6 reset p2", s_p2, 0);
    check("t6 reset winner", s_win, 0);
    check("t6 reset pulse", s_pulse, 0);
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
